ifetch_seq_ctrl: RTL
====================

Name: ifetch_seq_ctrl

Overview:
- Sequencing controller for the instruction-fetch datapath (PC register, PC+4 adder, branch adder, branch/jump muxes).
- Owns the instruction-memory request/acknowledge handshake.
- Issues PC write-enable and PC-source select, and holds the fetched instruction register with a valid flag toward decode.
- Captures branch/jump redirects from decode and discards wrong-path instructions.

Parameters:
- TIMEOUT_CYC, 16, cycles `imem_req` may stay high without `imem_ack` before fetch error (used only with the optional feature).
- RST_INSTR, 32'h0000_0000, value loaded into `ir_out` on reset and on flush.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_in  input  1  decode cannot accept an instruction this cycle.
- br_in  input  1  decode holds a conditional branch.
- zero_in  input  1  ALU zero flag for that branch.
- jmp_in  input  1  decode holds an unconditional jump.
- imem_ack  input  1  instruction memory returns data this cycle.
- imem_rdata  input  32  instruction word, valid with `imem_ack`.
- imem_req  output  1  fetch request at current PC (combinational).
- pc_we  output  1  PC register load enable (combinational).
- pc_sel  output  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = reserved/never driven.
- ir_out  output  32  registered instruction to decode.
- if_valid  output  1  `ir_out` holds a valid, unconsumed instruction.
- flush  output  1  registered 1-cycle pulse when a redirect is applied.
- fetch_err  output  1  sticky fetch timeout (0 when the feature is compiled out).

Behaviour:
- **Reset.** Synchronous, active-high; `clk`/`rst` as above. While `rst` is high:
  - state = S_BOOT; `ir_out` = RST_INSTR.
  - `if_valid`, `flush`, `fetch_err` = 0; pending-redirect flag = 0; timeout counter = 0.
  - `imem_req`, `pc_we` = 0 (forced, independent of other inputs).
- **States.** S_BOOT → S_REQ unconditionally after one cycle; S_ERR is reachable only with the optional feature. The first `imem_req` is in the 2nd cycle after `rst` falls.
- **Redirect detection.**
  - `redir_now = jmp_in | (br_in & zero_in)`.
  - `redir_sel = 2` if `jmp_in`, else 1; jump has priority over branch.
- **Pending redirect.**
  - `redir_now` with no pending redirect and not applied this cycle → store `pend_vld = 1`, `pend_sel = redir_sel`.
  - A later `redir_now` while `pend_vld` is set is ignored, since it comes from a wrong-path instruction.
  - Effective redirect: `eff = pend_vld | redir_now`, `eff_sel = pend_vld ? pend_sel : redir_sel`.
- **Consumption.** An instruction is consumed at an edge where `if_valid = 1` and `stall_in = 0`.
- **Request.** `imem_req = (state == S_REQ) & ~(if_valid & stall_in & ~eff)`. `imem_ack` is ignored when `imem_req = 0`.
- **Accepted ack, no `eff`:**
  - `pc_we = 1`, `pc_sel = 0`.
  - `ir_out <= imem_rdata`, `if_valid <= 1`.
- **Accepted ack with `eff`:**
  - Data is discarded; `pc_we = 1`, `pc_sel = eff_sel`.
  - `if_valid <= 0`, `ir_out <= RST_INSTR`, `flush <= 1`, `pend_vld <= 0`.
- **`eff` while `imem_req = 0` in S_REQ:** redirect applied immediately with the same actions as an accepted ack with `eff`.
- **`eff` while `imem_req = 1` without ack:**
  - PC is not written, because the address must stay stable mid-request.
  - `if_valid <= 0` at once (held instruction is wrong-path).
  - Redirect becomes pending and is applied at the ack.
- **No accepted ack and no redirect:** `pc_we = 0`, `pc_sel = 0`.
- **`if_valid` clear on consumption.** Cleared on consumption unless a new accepted ack sets it in the same edge; same-edge consume and load is the back-to-back case.
- **Stalls.** `stall_in` never blocks redirect application.

Optional Feature:
- Macro: IFETCH_TIMEOUT_EN.
- **Defined.**
  - A counter increments each cycle with `imem_req = 1` and `imem_ack = 0`; it clears on accepted ack or when `imem_req = 0`.
  - When the count reaches TIMEOUT_CYC: state → S_ERR, `imem_req = 0`, `pc_we = 0`, `fetch_err <= 1`, `if_valid <= 0`.
  - S_ERR is exited only by `rst`.
- **Undefined.** No counter or S_ERR; `fetch_err` is tied 0; the controller waits indefinitely.

Decomposition:
- Package `ifetch_pkg`:
  - state encodings S_BOOT = 2'd0, S_REQ = 2'd1, S_ERR = 2'd2.
  - PC_SEL_SEQ = 2'd0, PC_SEL_BR = 2'd1, PC_SEL_JMP = 2'd2.
- Sub-module `ifetch_redirect_latch`: holds `pend_vld`/`pend_sel` and drives `eff`/`eff_sel`.

Test Plan:
- **Reset to first fetch:** `rst` high 2 cycles then low, `imem_ack` tied 1 → `imem_req` = 0 in the first cycle after reset, then 1; `pc_we` = 1, `pc_sel` = 0 every cycle; `if_valid` = 1 from the 3rd cycle after reset.
- **Stall hold:**
  - `ir_out` = 32'h2002_0005, `if_valid` = 1, `stall_in` = 1 for 3 cycles → `imem_req` = 0, `pc_we` = 0, `ir_out` unchanged.
  - `stall_in` falls → `imem_req` = 1 the same cycle.
- **Taken branch during pending request:** `br_in` = 1, `zero_in` = 1 while `imem_ack` = 0; ack 2 cycles later with 32'hDEAD_BEEF → `if_valid` = 0, `pc_sel` = 1, `pc_we` = 1 at the ack, `flush` pulses once, `ir_out` = RST_INSTR.
- **Jump/branch priority and ignored second redirect:** `jmp_in` = `br_in` = `zero_in` = 1 with ack in the same cycle → `pc_sel` = 2. A `br_in` & `zero_in` arriving while a redirect is pending → `pc_sel` still equals the first `pend_sel`.
- **Untaken branch:** `br_in` = 1, `zero_in` = 0 → no flush, `pc_sel` = 0.
- **Timeout (IFETCH_TIMEOUT_EN, TIMEOUT_CYC = 4):** `imem_ack` held 0 → `fetch_err` = 1 after 4 request cycles; `imem_req` = 0 thereafter until `rst`.

Source files
------------

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared state and PC-source encodings for the fetch sequencer
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_ERR  = 2'd2
    } ifetch_state_t;

    localparam logic [1:0] PC_SEL_SEQ = 2'd0;
    localparam logic [1:0] PC_SEL_BR  = 2'd1;
    localparam logic [1:0] PC_SEL_JMP = 2'd2;

endpackage

// File: rtl/ifetch_redirect_latch.sv
// rtl/ifetch_redirect_latch.sv - holds one pending branch/jump redirect until it is applied
module ifetch_redirect_latch
    import ifetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       redir_now_i,
    input  logic [1:0] redir_sel_i,
    input  logic       apply_i,
    output logic       eff_o,
    output logic [1:0] eff_sel_o
);

    logic       pend_vld_q;
    logic [1:0] pend_sel_q;

    // The first redirect wins; later ones come from wrong-path instructions and are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld_q <= 1'b0;
            pend_sel_q <= PC_SEL_SEQ;
        end else if (apply_i) begin
            pend_vld_q <= 1'b0;
            pend_sel_q <= PC_SEL_SEQ;
        end else if (redir_now_i && !pend_vld_q) begin
            pend_vld_q <= 1'b1;
            pend_sel_q <= redir_sel_i;
        end
    end

    assign eff_o     = pend_vld_q | redir_now_i;
    assign eff_sel_o = pend_vld_q ? pend_sel_q : redir_sel_i;

endmodule

// File: rtl/ifetch_seq_ctrl.sv
// rtl/ifetch_seq_ctrl.sv - instruction-fetch sequencer; optional fetch timeout via IFETCH_TIMEOUT_EN
module ifetch_seq_ctrl
    import ifetch_pkg::*;
#(
    parameter int          TIMEOUT_CYC = 16,
    parameter logic [31:0] RST_INSTR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        br_in,
    input  logic        zero_in,
    input  logic        jmp_in,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [31:0] ir_out,
    output logic        if_valid,
    output logic        flush,
    output logic        fetch_err
);

    ifetch_state_t state_q;
    logic [31:0]   ir_q;
    logic          valid_q;
    logic          flush_q;

    logic       redir_now;
    logic [1:0] redir_sel;
    logic       eff;
    logic [1:0] eff_sel;
    logic       fetch_ok;
    logic       ack_acc;
    logic       apply;
    logic       to_hit;

    assign redir_now = jmp_in | (br_in & zero_in);
    assign redir_sel = jmp_in ? PC_SEL_JMP : PC_SEL_BR;

    ifetch_redirect_latch u_redir (
        .clk         (clk),
        .rst         (rst),
        .redir_now_i (redir_now),
        .redir_sel_i (redir_sel),
        .apply_i     (apply),
        .eff_o       (eff),
        .eff_sel_o   (eff_sel)
    );

    // A stalled valid instruction blocks new fetches unless a redirect makes it wrong-path.
    assign fetch_ok = (state_q == S_REQ) & ~rst;
    assign imem_req = fetch_ok & ~(valid_q & stall_in & ~eff);
    assign ack_acc  = imem_req & imem_ack;
    // Redirects land on an ack or when no request is outstanding, never mid-request.
    assign apply    = fetch_ok & eff & (~imem_req | imem_ack);
    assign pc_we    = ack_acc | apply;
    assign pc_sel   = apply ? eff_sel : PC_SEL_SEQ;

`ifdef IFETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          err_q;

    // Count consecutive unanswered request cycles.
    always_comb begin
        cnt_d = '0;
        if (imem_req && !imem_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end
    assign to_hit = (cnt_d == CW'(TIMEOUT_CYC));

    // Wait counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetch_err = err_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYC);
    assign to_hit         = 1'b0;
    assign fetch_err      = 1'b0;
`endif

    // Sequencer FSM with the instruction register, valid flag and flush pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BOOT;
            ir_q    <= RST_INSTR;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            flush_q <= 1'b0;
            case (state_q)
                S_BOOT: state_q <= S_REQ;
                S_REQ: begin
`ifdef IFETCH_TIMEOUT_EN
                    if (to_hit) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end else
`endif
                    if (apply) begin
                        ir_q    <= RST_INSTR;
                        valid_q <= 1'b0;
                        flush_q <= 1'b1;
                    end else if (ack_acc) begin
                        ir_q    <= imem_rdata;
                        valid_q <= 1'b1;
                    end else if (eff || (valid_q && !stall_in)) begin
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

    assign ir_out   = ir_q;
    assign if_valid = valid_q;
    assign flush    = flush_q;

endmodule
